// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants and coordinate type
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int DIV_DEF      = 4;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  // Narrow an integer timing value to the coordinate width.
  function automatic coord_t to_coord(input int v);
    return coord_t'(v);
  endfunction

  // Last position of a scan axis made of active, porch, sync and porch spans.
  function automatic int axis_last(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp - 1;
  endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// rtl/vga_scan_gen_if.sv - scan generator control and timing outputs
interface vga_scan_gen_if;
  import vga_timing_pkg::*;

  logic       scan_en;
  coord_t     x;
  coord_t     y;
  logic       video_on;
  logic       hsync_n;
  logic       vsync_n;
  logic       pix_tick;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    input  scan_en,
    output x, y, video_on, hsync_n, vsync_n, pix_tick, frame_start, frame_cnt
  );

  modport slave (
    output scan_en,
    input  x, y, video_on, hsync_n, vsync_n, pix_tick, frame_start, frame_cnt
  );
endinterface

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - pixel clock-enable divider with hold
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic adv,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] div_cnt;

  // adv lets the caller update in the same edge; dropping en on that clk cancels it
  assign adv = en && (div_cnt == LAST);

  // divider counts only while enabled; tick is the registered copy of adv
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= adv;
      if (adv) begin
        div_cnt <= '0;
      end else if (en) begin
        div_cnt <= div_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA raster scan counters and sync decode
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int DIV      = DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_scan_gen_if.master  vga
);

  localparam coord_t H_LAST = to_coord(axis_last(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam coord_t V_LAST = to_coord(axis_last(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam coord_t H_ACT  = to_coord(H_ACTIVE);
  localparam coord_t V_ACT  = to_coord(V_ACTIVE);
  localparam coord_t HS_BEG = to_coord(H_ACTIVE + H_FP);
  localparam coord_t HS_END = to_coord(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_BEG = to_coord(V_ACTIVE + V_FP);
  localparam coord_t VS_END = to_coord(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       adv;
  coord_t     x_q, y_q, x_nxt, y_nxt;
  logic       video_on_q, hsync_n_q, vsync_n_q, frame_start_q;
  logic [7:0] frame_cnt_q;

  clk_en_div #(.DIV(DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (vga.scan_en),
    .adv   (adv),
    .tick  (vga.pix_tick)
  );

  // next raster position: x wraps at end of line, y steps on that wrap
  always_comb begin
    x_nxt = x_q + 1'b1;
    y_nxt = y_q;
    if (x_q == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end
  end

  // all decode is taken from the next position so every output moves on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      video_on_q    <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      frame_start_q <= 1'b0;
      if (adv) begin
        x_q        <= x_nxt;
        y_q        <= y_nxt;
        video_on_q <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
        hsync_n_q  <= !((x_nxt >= HS_BEG) && (x_nxt <= HS_END));
        vsync_n_q  <= !((y_nxt >= VS_BEG) && (y_nxt <= VS_END));
        if ((x_nxt == '0) && (y_nxt == '0)) begin
          frame_start_q <= 1'b1;
          frame_cnt_q   <= frame_cnt_q + 8'd1;
        end
      end
    end
  end

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.video_on    = video_on_q;
  assign vga.hsync_n     = hsync_n_q;
  assign vga.vsync_n     = vsync_n_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - directed bench for vga_scan_gen
module tb_vga_scan_gen;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vga_scan_gen_if va ();
  vga_scan_gen_if vb ();

  vga_scan_gen u_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .vga   (va)
  );

  vga_scan_gen #(
    .DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .vga   (vb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low;
    int ex, ey, p;
    int pt_bad, fs_bad, starts, vs_low;
    logic exp_tick, exp_fs;
    localparam int NCLK = 2 * 56 * 256 + 2;

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    va.scan_en = 1'b1;
    vb.scan_en = 1'b1;
    clks(3);

    chk("rst_x", va.x, 799);
    chk("rst_y", va.y, 524);
    chk("rst_video_on", va.video_on, 0);
    chk("rst_hsync_n", va.hsync_n, 1);
    chk("rst_vsync_n", va.vsync_n, 1);
    chk("rst_pix_tick", va.pix_tick, 0);
    chk("rst_frame_start", va.frame_start, 0);
    chk("rst_frame_cnt", va.frame_cnt, 0);

    rst_a_n = 1'b1;
    clks(3);
    chk("pre_tick_pix", va.pix_tick, 0);
    chk("pre_tick_x", va.x, 799);
    clks(1);
    chk("first_x", va.x, 0);
    chk("first_y", va.y, 0);
    chk("first_frame_start", va.frame_start, 1);
    chk("first_frame_cnt", va.frame_cnt, 1);
    chk("first_video_on", va.video_on, 1);
    chk("first_pix_tick", va.pix_tick, 1);

    hs_low = 0;
    for (int k = 1; k <= 800; k++) begin
      clks(1);
      chk("pix_tick_gap", va.pix_tick, 0);
      if (k == 1) chk("frame_start_width", va.frame_start, 0);
      clks(3);
      ex = k % 800;
      ey = k / 800;
      chk("line_x", va.x, ex);
      chk("line_y", va.y, ey);
      chk("line_pix_tick", va.pix_tick, 1);
      chk("line_video_on", va.video_on, (ex < 640) && (ey < 480));
      chk("line_hsync_n", va.hsync_n, !((ex >= 656) && (ex <= 751)));
      if (va.hsync_n === 1'b0) hs_low++;
    end
    chk("hsync_low_ticks", hs_low, 96);
    chk("line_wrap_no_frame_start", va.frame_start, 0);
    chk("line_wrap_frame_cnt", va.frame_cnt, 1);

    clks(400);
    chk("at100_x", va.x, 100);
    chk("at100_y", va.y, 1);
    clks(1);
    va.scan_en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      clks(1);
      chk("frz_x", va.x, 100);
      chk("frz_y", va.y, 1);
      chk("frz_pix_tick", va.pix_tick, 0);
      chk("frz_frame_start", va.frame_start, 0);
      chk("frz_video_on", va.video_on, 1);
      chk("frz_hsync_n", va.hsync_n, 1);
      chk("frz_vsync_n", va.vsync_n, 1);
      chk("frz_frame_cnt", va.frame_cnt, 1);
    end
    va.scan_en = 1'b1;
    clks(2);
    chk("resume_wait_x", va.x, 100);
    chk("resume_wait_pix", va.pix_tick, 0);
    clks(1);
    chk("resume_x", va.x, 101);
    chk("resume_pix", va.pix_tick, 1);

    clks(3);
    chk("pre_cancel_x", va.x, 101);
    va.scan_en = 1'b0;
    clks(5);
    chk("cancel_x", va.x, 101);
    chk("cancel_pix", va.pix_tick, 0);
    va.scan_en = 1'b1;
    clks(1);
    chk("after_cancel_x", va.x, 102);
    chk("after_cancel_pix", va.pix_tick, 1);

    @(posedge clk);
    #2;
    rst_a_n = 1'b0;
    #1;
    chk("async_rst_x", va.x, 799);
    chk("async_rst_y", va.y, 524);
    chk("async_rst_video_on", va.video_on, 0);
    chk("async_rst_hsync_n", va.hsync_n, 1);
    chk("async_rst_vsync_n", va.vsync_n, 1);
    chk("async_rst_frame_cnt", va.frame_cnt, 0);

    clks(1);
    rst_b_n = 1'b1;
    pt_bad = 0;
    fs_bad = 0;
    starts = 0;
    vs_low = 0;
    for (int c = 1; c <= NCLK; c++) begin
      clks(1);
      exp_tick = (c % 2 == 0);
      exp_fs   = exp_tick && ((((c / 2) - 1) % 56) == 0);
      if (vb.pix_tick !== exp_tick) pt_bad++;
      if (vb.frame_start !== exp_fs) fs_bad++;
      if (vb.frame_start === 1'b1) begin
        starts++;
        chk("frame_cnt_at_start", vb.frame_cnt, starts % 256);
      end
      if (exp_tick && (c / 2 <= 56)) begin
        p  = (c / 2) - 1;
        ex = p % 8;
        ey = p / 8;
        chk("small_x", vb.x, ex);
        chk("small_y", vb.y, ey);
        chk("small_video_on", vb.video_on, (ex < 4) && (ey < 3));
        chk("small_hsync_n", vb.hsync_n, !((ex >= 5) && (ex <= 6)));
        chk("small_vsync_n", vb.vsync_n, !((ey >= 4) && (ey <= 5)));
        if (vb.vsync_n === 1'b0) vs_low++;
      end
    end
    chk("pix_tick_pattern_errs", pt_bad, 0);
    chk("frame_start_pattern_errs", fs_bad, 0);
    chk("frame_start_count", starts, 257);
    chk("vsync_low_ticks", vs_low, 16);
    chk("final_frame_cnt", vb.frame_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning system clocks per pixel (pixel-tick period).
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, meaning horizontal timing in pixels (H_TOTAL = 800).
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, meaning vertical timing in lines (V_TOTAL = 525).
REQ-004 SHALL have port clk, input, 1, the single system clock; all flops on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port scan_en, input, 1, high = scanning runs; low = divider and counters hold.
REQ-007 SHALL have port x, output, 10, current pixel column.
REQ-008 SHALL have port y, output, 10, current pixel row.
REQ-009 SHALL have port video_on, output, 1, high when (x,y) is inside the active area.
REQ-010 SHALL have port hsync_n, output, 1, active-low horizontal sync.
REQ-011 SHALL have port vsync_n, output, 1, active-low vertical sync.
REQ-012 SHALL have port pix_tick, output, 1, one-clk pulse marking each pixel advance.
REQ-013 SHALL have port frame_start, output, 1, one-clk pulse when the scan enters (0,0).
REQ-014 SHALL have port frame_cnt, output, 8, count of frames started, modulo 256.

Function
REQ-015 SHALL run div_cnt 0..DIV-1 while scan_en=1, with pix_tick=1 in the clk where div_cnt==DIV-1, so pix_tick fires once per DIV clks.
REQ-016 SHALL increment x on each pix_tick and wrap it from H_TOTAL-1 to 0.
REQ-017 SHALL increment y on the pix_tick where x wraps, and wrap y from V_TOTAL-1 to 0 on that same tick.
REQ-018 SHALL register all outputs so that x, y, video_on, hsync_n, vsync_n all change in the same clk and are mutually consistent (zero skew).
REQ-019 SHALL drive video_on = (x < H_ACTIVE) && (y < V_ACTIVE).
REQ-020 SHALL drive hsync_n = 0 for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751] at defaults, and 1 elsewhere.
REQ-021 SHALL drive vsync_n = 0 for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491] at defaults, and 1 elsewhere.
REQ-022 SHALL assert frame_start for exactly one clk: the clk in which x,y become (0,0).
REQ-023 SHALL increment frame_cnt in the same clk as frame_start, wrapping 255 -> 0.
REQ-024 SHALL, while scan_en=0, freeze div_cnt, x, y, video_on, hsync_n, vsync_n and frame_cnt, and hold pix_tick and frame_start at 0; on re-enable, counting resumes from the held div_cnt.
REQ-025 SHALL, if scan_en falls in the clk a tick would fire, suppress that tick (no partial advance).

Reset
REQ-026 SHALL, when rst_n=0, asynchronously force div_cnt=0, x=H_TOTAL-1 (799), y=V_TOTAL-1 (524), video_on=0, hsync_n=1, vsync_n=1, pix_tick=0, frame_start=0, frame_cnt=0.
REQ-027 SHALL, after rst_n deasserts with scan_en=1, land on (0,0) at the first pix_tick (DIV clks later) with frame_start=1 and frame_cnt=1.
REQ-028 SHALL, when reset is asserted mid-frame, restore the REQ-026 values immediately, without waiting for a clk edge.

Structure
REQ-029 SHALL take all timing constants (H_*/V_* values, H_TOTAL, V_TOTAL, the sync start/end positions) and the 10-bit coordinate width from shared package vga_timing_pkg, which the glyph renderers also use.
REQ-030 SHALL implement the pixel divider (REQ-015, REQ-024) as sub-module clk_en_div; the h/v counters and decode remain in vga_scan_gen.

Verification
REQ-031 SHALL be verified by: release reset with scan_en=1 -> 4 clks later x=0, y=0, frame_start=1, frame_cnt=1, video_on=1.
REQ-032 SHALL be verified by: run one line -> hsync_n low exactly 96 ticks (x=656..751), video_on low for x>=640, x wraps 799 -> 0 while y increments.
REQ-033 SHALL be verified by: run one frame -> vsync_n low for y=490..491 only, frame_start pulses once per 420000 ticks (1680000 clks).
REQ-034 SHALL be verified by: drop scan_en at x=100 for 37 clks -> all outputs frozen, no pix_tick; on resume, x=101 follows after the remaining divider clks.
REQ-035 SHALL be verified by: run 256 frames -> frame_cnt wraps 255 -> 0 on the 256th frame_start.
REQ-036 SHALL be verified by: assert rst_n=0 mid-frame between clk edges -> outputs take REQ-026 values immediately.
